// File: rtl/branch_pred_tracker_pkg.sv
// Shared types and constants for the branch prediction tracker.
// bp_entry_t is the canonical 32-bit-PC layout of one tracked prediction.
package branch_pred_tracker_pkg;

  localparam int BP_WIDTH = 32;
  localparam int PC_STEP  = 4;

  typedef struct packed {
    logic                pred;
    logic [BP_WIDTH-1:0] target;
    logic [BP_WIDTH-1:0] fall;
  } bp_entry_t;

endpackage

// File: rtl/branch_pred_tracker_sat_counter.sv
// Saturating up-counter used for predictor statistics.
// The counter holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] q
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + CNT_ONE;
    end
  end

endmodule

// File: rtl/branch_pred_tracker.sv
// In-order tracker of fetched branch predictions; compares the oldest entry
// against the EX outcome, flags mispredicts, supplies the redirect PC and flushes younger entries.
module branch_pred_tracker
  import branch_pred_tracker_pkg::*;
#(
  parameter int WIDTH = BP_WIDTH,
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             push_pred,
  input  logic [WIDTH-1:0] push_target,
  input  logic [WIDTH-1:0] push_fall,
  input  logic             resolve,
  input  logic             resolve_taken,
  output logic             prediction,
  output logic             mispredict,
  output logic [WIDTH-1:0] redirect_pc,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic             underflow,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);

  // Same field layout as bp_entry_t, but sized by this instance's WIDTH.
  typedef struct packed {
    logic             pred;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] fall;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count;

  entry_t head;
  logic   pop_ok;
  logic   push_blocked;
  logic   push_ok;

  always_comb begin
    head         = mem[rd_ptr];
    empty        = (count == '0);
    full         = (count == FULL_CNT);
    pop_ok       = resolve && !empty;
    mispredict   = pop_ok && (resolve_taken != head.pred);
    prediction   = empty ? 1'b0 : head.pred;
    redirect_pc  = '0;
    if (!empty) begin
      redirect_pc = resolve_taken ? head.target : head.fall;
    end
    // A correct pop in the same cycle frees a slot for the incoming push.
    push_blocked = full && !(pop_ok && !mispredict);
    push_ok      = push && !push_blocked && !mispredict;
  end

  // Storage is not reset: every read is gated by empty.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= '{pred: push_pred, target: push_target, fall: push_fall};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (mispredict) begin
      rd_ptr <= rd_ptr + PTR_ONE;
      wr_ptr <= rd_ptr + PTR_ONE;
      count  <= '0;
    end else begin
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (push_ok && !pop_ok) begin
        count <= count + CNT_ONE;
      end else if (pop_ok && !push_ok) begin
        count <= count - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push && push_blocked) begin
        overflow <= 1'b1;
      end
      if (resolve && empty) begin
        underflow <= 1'b1;
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_branch_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (pop_ok),
    .q     (branch_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_mispred_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (mispredict),
    .q     (mispred_cnt)
  );

endmodule

// File: tb/tb_branch_pred_tracker.sv
// Directed bench for branch_pred_tracker with a queue-based scoreboard of tracked predictions.
// Narrow statistics counters so saturation is reachable in a few steps.
module tb_branch_pred_tracker;
  import branch_pred_tracker_pkg::*;

  localparam int WIDTH   = 32;
  localparam int DEPTH   = 4;
  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             reset;
  logic             push;
  logic             push_pred;
  logic [WIDTH-1:0] push_target;
  logic [WIDTH-1:0] push_fall;
  logic             resolve;
  logic             resolve_taken;
  logic             prediction;
  logic             mispredict;
  logic [WIDTH-1:0] redirect_pc;
  logic             full;
  logic             empty;
  logic             overflow;
  logic             underflow;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  int n_vec = 0;
  int n_err = 0;

  bp_entry_t mq[$];
  logic      m_over;
  logic      m_under;
  int        m_bcnt;
  int        m_mcnt;

  branch_pred_tracker #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .push          (push),
    .push_pred     (push_pred),
    .push_target   (push_target),
    .push_fall     (push_fall),
    .resolve       (resolve),
    .resolve_taken (resolve_taken),
    .prediction    (prediction),
    .mispredict    (mispredict),
    .redirect_pc   (redirect_pc),
    .full          (full),
    .empty         (empty),
    .overflow      (overflow),
    .underflow     (underflow),
    .branch_cnt    (branch_cnt),
    .mispred_cnt   (mispred_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_over  = 1'b0;
    m_under = 1'b0;
    m_bcnt  = 0;
    m_mcnt  = 0;
  endtask

  task automatic check_state(input string phase);
    check_output({phase, ":empty"},       32'(empty),       32'(mq.size() == 0));
    check_output({phase, ":full"},        32'(full),        32'(mq.size() == DEPTH));
    check_output({phase, ":overflow"},    32'(overflow),    32'(m_over));
    check_output({phase, ":underflow"},   32'(underflow),   32'(m_under));
    check_output({phase, ":branch_cnt"},  32'(branch_cnt),  32'(m_bcnt));
    check_output({phase, ":mispred_cnt"}, 32'(mispred_cnt), 32'(m_mcnt));
  endtask

  task automatic do_reset();
    @(negedge clk);
    push    = 1'b0;
    resolve = 1'b0;
    reset   = 1'b1;
    #2;
    reset   = 1'b0;
    model_clear();
  endtask

  // One cycle: drive at negedge, check zero-latency outputs, step the model, check state after the edge.
  task automatic apply_stimulus(input logic p, input logic pp, input logic [31:0] pt,
                                input logic [31:0] pf, input logic r, input logic rt);
    logic      m_empty;
    logic      m_full;
    logic      e_mis;
    logic      e_pred;
    logic      blocked;
    logic [31:0] e_redir;
    bp_entry_t hd;
    @(negedge clk);
    push          = p;
    push_pred     = pp;
    push_target   = pt;
    push_fall     = pf;
    resolve       = r;
    resolve_taken = rt;
    #1;
    m_empty = (mq.size() == 0);
    m_full  = (mq.size() == DEPTH);
    hd      = m_empty ? '0 : mq[0];
    e_pred  = m_empty ? 1'b0 : hd.pred;
    e_mis   = r && !m_empty && (rt != hd.pred);
    e_redir = m_empty ? 32'h0 : (rt ? hd.target : hd.fall);
    check_output("prediction",  32'(prediction), 32'(e_pred));
    check_output("mispredict",  32'(mispredict), 32'(e_mis));
    check_output("redirect_pc", redirect_pc,     e_redir);
    blocked = m_full && !(r && !m_empty && !e_mis);
    if (p && blocked) m_over = 1'b1;
    if (r && m_empty) m_under = 1'b1;
    if (r && !m_empty) begin
      void'(mq.pop_front());
      if (m_bcnt < CNT_MAX) m_bcnt++;
    end
    if (e_mis) begin
      mq.delete();
      if (m_mcnt < CNT_MAX) m_mcnt++;
    end else if (p && !blocked) begin
      mq.push_back('{pred: pp, target: pt, fall: pf});
    end
    @(posedge clk);
    #1;
    push    = 1'b0;
    resolve = 1'b0;
    check_state("post_edge");
  endtask

  task automatic push_one(input logic pp, input logic [31:0] pc, input logic [31:0] tgt);
    apply_stimulus(1'b1, pp, tgt, pc + PC_STEP, 1'b0, 1'b0);
  endtask

  task automatic resolve_one(input logic taken);
    apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, taken);
  endtask

  initial begin
    reset         = 1'b1;
    push          = 1'b0;
    push_pred     = 1'b0;
    push_target   = '0;
    push_fall     = '0;
    resolve       = 1'b0;
    resolve_taken = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check_state("reset");
    check_output("reset:prediction", 32'(prediction), 32'h0);
    check_output("reset:redirect",   redirect_pc,     32'h0);

    // Asynchronous reset in the middle of a stream.
    resolve_one(1'b1);
    push_one(1'b1, 32'h10, 32'h400);
    push_one(1'b0, 32'h14, 32'h404);
    push_one(1'b1, 32'h18, 32'h408);
    resolve_one(1'b1);
    @(negedge clk);
    #2;
    reset = 1'b1;
    model_clear();
    #1;
    check_state("async_reset");
    #1;
    reset = 1'b0;

    // Correct prediction.
    do_reset();
    apply_stimulus(1'b1, 1'b1, 32'h100, 32'h44, 1'b0, 1'b0);
    resolve_one(1'b1);

    // Mispredict with a wrong-path push in the same cycle.
    do_reset();
    apply_stimulus(1'b1, 1'b0, 32'h80,  32'h24, 1'b0, 1'b0);
    push_one(1'b1, 32'h34, 32'h200);
    push_one(1'b0, 32'h38, 32'h300);
    apply_stimulus(1'b1, 1'b1, 32'h600, 32'h604, 1'b1, 1'b1);
    resolve_one(1'b0);
    push_one(1'b1, 32'h500, 32'h900);
    resolve_one(1'b1);

    // Fill, overflow, then wrap the pointers with push+resolve pairs.
    do_reset();
    for (int i = 0; i < DEPTH; i++) push_one(i[0], 32'h1000 + 32'(i * 16), 32'h2000 + 32'(i * 16));
    push_one(1'b1, 32'h1ff0, 32'h2ff0);
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(1'b1, ~i[0], 32'h3000 + 32'(i * 16), 32'h3104 + 32'(i * 16), 1'b1, mq[0].pred);
    end
    for (int i = 0; i < DEPTH; i++) resolve_one(mq[0].pred);

    // Underflow stays sticky.
    resolve_one(1'b0);
    apply_stimulus(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

    // Counter saturation.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      push_one(1'b0, 32'h40 + 32'(i * 4), 32'h700 + 32'(i * 4));
      resolve_one(1'b1);
    end
    check_output("sat:mispred_cnt", 32'(mispred_cnt), 32'(CNT_MAX));
    check_output("sat:branch_cnt",  32'(branch_cnt),  32'(CNT_MAX));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/branch_pred_tracker.md
Name: branch_pred_tracker

Overview:
- Sits beside the fetch stage and records every prediction issued for a fetched branch: predicted direction, predicted-taken target PC and fall-through PC.
- Holds these entries in order until the branch resolves in EX, then supplies the matching prediction to the misprediction-flush logic.
- On a mismatch it asserts mispredict, drives the corrected redirect PC and discards all younger tracked branches.
- Keeps saturating statistics counters for predictor evaluation.

Parameters:
- WIDTH, 32, PC width in bits.
- DEPTH, 4, number of in-flight branches tracked (power of 2, at least 2).
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  Rising-edge clock.
- reset  in  1  Asynchronous reset, active-high.
- push  in  1  Fetch issued a predicted branch this cycle.
- push_pred  in  1  Predicted direction (1 = taken).
- push_target  in  WIDTH  Branch target PC.
- push_fall  in  WIDTH  Fall-through PC (branch PC + 4).
- resolve  in  1  EX resolved the oldest tracked branch this cycle.
- resolve_taken  in  1  Actual branch outcome.
- prediction  out  1  Head entry's predicted direction; 0 when empty.
- mispredict  out  1  Combinational: resolve & !empty & (resolve_taken != prediction).
- redirect_pc  out  WIDTH  Combinational: resolve_taken ? head target : head fall-through; 0 when empty.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- overflow  out  1  Sticky: a push was attempted while full.
- underflow  out  1  Sticky: a resolve was attempted while empty.
- branch_cnt  out  CNT_W  Saturating count of accepted resolves.
- mispred_cnt  out  CNT_W  Saturating count of mispredicts.

Behaviour:
- Reset (async, active-high):
  - Read pointer, write pointer and count go to 0.
  - overflow, underflow, branch_cnt and mispred_cnt go to 0.
  - Storage contents are don't-care; outputs are gated by empty.
- Storage: circular buffer of DEPTH entries {pred, target, fall}. Pointers are log2(DEPTH) bits wide and wrap naturally.
- Push accepted when push & !full & !mispredict:
  - Entry is written at the write pointer.
  - Write pointer and count increment at the clock edge.
- Push while full: entry is dropped and overflow is set. No other state changes from the push.
- Resolve accepted when resolve & !empty:
  - Head is consumed and branch_cnt increments (saturating at all-ones).
  - If mispredict is also asserted, the flush rules below apply.
- Resolve while empty: underflow is set. mispredict stays 0 and counters are unchanged.
- Mispredict edge:
  - All entries are flushed: the write pointer takes the read pointer + 1 value and count becomes 0.
  - A push in the same cycle is discarded, because that instruction is on the wrong path.
  - mispred_cnt increments (saturating).
- Simultaneous push and correct resolve: one entry in, one entry out, count unchanged. This is legal even when full, because the pop frees the slot.
  - The full condition for this case is evaluated as (count == DEPTH) & !(resolve & !empty & !mispredict).
- Latency:
  - A pushed entry is visible at the head one cycle after the push edge if the buffer was empty.
  - mispredict and redirect_pc are zero-latency relative to resolve.
- Sticky flags clear only on reset.

Decomposition:
- Shared package: typedef bp_entry_t {pred, target[WIDTH], fall[WIDTH]} and constant PC_STEP = 4.
- One natural sub-module: sat_counter (parameter CNT_W; ports inc, q, async reset), instantiated twice.
- The buffer itself stays inline.

Test Plan:
- Reset mid-stream: push 3 entries, assert reset asynchronously between edges → empty=1, count 0, counters 0 immediately, without waiting for an edge.
- Correct prediction: push pred=1, target=0x100, fall=0x44; next cycle resolve taken=1 → mispredict=0, redirect_pc=0x100, branch_cnt=1, empty=1.
- Mispredict with flush: push A (pred=0, fall=0x24, target=0x80), then B and C; resolve A with taken=1 and a simultaneous push D → mispredict=1, redirect_pc=0x80; next cycle empty=1, D not stored, mispred_cnt=1.
- Full and wrap-around: push 4 (DEPTH) → full=1; 5th push → overflow=1, contents unchanged; then 6 alternating push+resolve cycles → head order preserved across pointer wrap, count stays 4.
- Underflow: resolve with empty=1 → underflow=1 sticky, mispredict=0, branch_cnt unchanged.
- Saturation: CNT_W=2, 5 mispredicts → mispred_cnt=3 and holds; branch_cnt=3 and holds.
